// File: rtl/if_id_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_id_fetch_stage
//
// Instruction-fetch stage of a classic in-order pipeline: the PC register,
// the instruction-memory address and the IF/ID pipeline register. Saturating
// stall and flush event counters are kept for performance debug.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   stall         load-use stall: hold PC and IF/ID
//   flush         bubble IF/ID without redirecting the PC
//   branch_taken  redirect the PC to branch_target (also bubbles IF/ID)
//   branch_target redirect address; the low two bits are ignored
//   imem_addr     instruction-memory address (the current PC)
//   imem_rdata    instruction word, combinational read of imem_addr
//   if_id_pc      PC of the instruction held in IF/ID
//   if_id_instr   instruction held in IF/ID
//   if_id_valid   IF/ID holds a real instruction
//   if_id_rs1     instr[19:15] when valid, else 0
//   if_id_rs2     instr[24:20] when valid, else 0
//   stall_cnt     saturating count of edges with a stall applied
//   flush_cnt     saturating count of edges with flush or branch_taken
// ---------------------------------------------------------------------------
module if_id_fetch_stage #(
   parameter int          XLEN      = 32,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             flush,
   input  logic             branch_taken,
   input  logic [XLEN-1:0]  branch_target,
   output logic [XLEN-1:0]  imem_addr,
   input  logic [XLEN-1:0]  imem_rdata,
   output logic [XLEN-1:0]  if_id_pc,
   output logic [XLEN-1:0]  if_id_instr,
   output logic             if_id_valid,
   output logic [4:0]       if_id_rs1,
   output logic [4:0]       if_id_rs2,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_next;
   logic            bubble;
   logic            stall_event;

   // A redirect overrides a stall; a plain flush only kills IF/ID.
   assign bubble      = branch_taken | flush;
   assign stall_event = stall & ~branch_taken;

   // NOTE: every variable driven in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      pc_next = pc + XLEN'(4);
      if (branch_taken) begin
         // Force word alignment of the redirect target.
         pc_next = branch_target & ~XLEN'(3);
      end else if (stall) begin
         pc_next = pc;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   // NOTE: reset is asynchronous; all state, including the counters, returns
   // to known values as soon as rst_n falls, without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC[XLEN-1:0];
      end else begin
         pc <= pc_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_pc    <= '0;
         if_id_instr <= NOP_INSTR[XLEN-1:0];
         if_id_valid <= 1'b0;
      end else if (bubble) begin
         // Bubble wins over stall; the PC field still tracks the fetch PC.
         if_id_pc    <= pc;
         if_id_instr <= NOP_INSTR[XLEN-1:0];
         if_id_valid <= 1'b0;
      end else if (!stall) begin
         if_id_pc    <= pc;
         if_id_instr <= imem_rdata;
         if_id_valid <= 1'b1;
      end
   end

   // Saturating event counters: hold at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_event && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (bubble && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

   assign imem_addr = pc;

   // Bubbles report x0 so they never match a nonzero destination register.
   assign if_id_rs1 = if_id_valid ? if_id_instr[19:15] : 5'd0;
   assign if_id_rs2 = if_id_valid ? if_id_instr[24:20] : 5'd0;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_fetch_stage
//
// Directed self-checking bench for if_id_fetch_stage. The instruction memory
// returns an address-derived word so each fetched instruction identifies its
// own PC. Counters are narrowed to 4 bits so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_if_id_fetch_stage;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic             stall;
   logic             flush;
   logic             branch_taken;
   logic [XLEN-1:0]  branch_target;
   logic [XLEN-1:0]  imem_addr;
   logic [XLEN-1:0]  imem_rdata;
   logic [XLEN-1:0]  if_id_pc;
   logic [XLEN-1:0]  if_id_instr;
   logic             if_id_valid;
   logic [4:0]       if_id_rs1;
   logic [4:0]       if_id_rs2;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   int passed = 0;
   int total  = 0;

   if_id_fetch_stage #(
      .XLEN      (XLEN),
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0013),
      .CNT_W     (CNT_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .flush         (flush),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .if_id_pc      (if_id_pc),
      .if_id_instr   (if_id_instr),
      .if_id_valid   (if_id_valid),
      .if_id_rs1     (if_id_rs1),
      .if_id_rs2     (if_id_rs2),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   // Address-tagged memory word: upper half is a marker, lower half the address.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return {16'hA5C3 ^ addr[31:16], addr[15:0]} ^ 32'h0139_0000;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_addr"},  imem_addr,   32'h0);
      check({tag, "_pc"},    if_id_pc,    32'h0);
      check({tag, "_instr"}, if_id_instr, 32'h13);
      check({tag, "_valid"}, 32'(if_id_valid), 32'h0);
      check({tag, "_scnt"},  32'(stall_cnt), 32'h0);
      check({tag, "_fcnt"},  32'(flush_cnt), 32'h0);
   endtask

   initial begin
      logic [31:0] w;
      rst_n         = 1'b0;
      stall         = 1'b0;
      flush         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;

      tick(2);
      check_reset_state("rst");
      rst_n = 1'b1;

      // Cycle 1: PC 0 presented, IF/ID still empty.
      check("c1_addr",  imem_addr, 32'h0);
      check("c1_valid", 32'(if_id_valid), 32'h0);
      tick();
      check("c2_addr",  imem_addr,   32'h4);
      check("c2_pc",    if_id_pc,    32'h0);
      check("c2_valid", 32'(if_id_valid), 32'h1);
      check("c2_instr", if_id_instr, mem_word(32'h0));
      tick(3);
      check("c5_addr",  imem_addr, 32'h10);
      check("c5_pc",    if_id_pc,  32'h0C);
      w = mem_word(32'h0C);
      check("c5_rs1",   32'(if_id_rs1), 32'(w[19:15]));
      check("c5_rs2",   32'(if_id_rs2), 32'(w[24:20]));

      // Three stalled edges at PC 0x10.
      stall = 1'b1;
      tick(3);
      check("stall_addr",  imem_addr,   32'h10);
      check("stall_pc",    if_id_pc,    32'h0C);
      check("stall_instr", if_id_instr, mem_word(32'h0C));
      check("stall_cnt",   32'(stall_cnt), 32'd3);
      stall = 1'b0;
      tick();
      check("resume_addr", imem_addr, 32'h14);
      check("resume_pc",   if_id_pc,  32'h10);
      tick(3);
      check("pre_br_addr", imem_addr, 32'h20);

      // Misaligned branch target 0x103 from PC 0x20.
      branch_taken  = 1'b1;
      branch_target = 32'h103;
      tick();
      branch_taken = 1'b0;
      check("br_addr",  imem_addr,   32'h100);
      check("br_valid", 32'(if_id_valid), 32'h0);
      check("br_instr", if_id_instr, 32'h13);
      check("br_pc",    if_id_pc,    32'h20);
      check("br_rs1",   32'(if_id_rs1), 32'h0);
      check("br_rs2",   32'(if_id_rs2), 32'h0);
      check("br_fcnt",  32'(flush_cnt), 32'd1);
      tick();
      check("tgt_pc",    if_id_pc,    32'h100);
      check("tgt_valid", 32'(if_id_valid), 32'h1);
      check("tgt_instr", if_id_instr, mem_word(32'h100));

      // Stall and branch together: redirect wins, stall not counted.
      stall         = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 32'h40;
      tick();
      stall        = 1'b0;
      branch_taken = 1'b0;
      check("sb_addr",  imem_addr, 32'h40);
      check("sb_valid", 32'(if_id_valid), 32'h0);
      check("sb_scnt",  32'(stall_cnt), 32'd3);
      check("sb_fcnt",  32'(flush_cnt), 32'd2);
      tick();
      check("sb2_addr", imem_addr, 32'h44);
      check("sb2_pc",   if_id_pc,  32'h40);

      // Redirect to 0x08, then a plain flush at PC 0x08.
      branch_taken  = 1'b1;
      branch_target = 32'h08;
      tick();
      branch_taken = 1'b0;
      check("fl_pre_addr", imem_addr, 32'h08);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_addr",  imem_addr, 32'h0C);
      check("fl_valid", 32'(if_id_valid), 32'h0);
      check("fl_instr", if_id_instr, 32'h13);
      check("fl_pc",    if_id_pc,  32'h08);
      check("fl_fcnt",  32'(flush_cnt), 32'd4);
      tick();
      check("fl2_pc",    if_id_pc, 32'h0C);
      check("fl2_valid", 32'(if_id_valid), 32'h1);

      // PC wrap: redirect to the top word, then free-run.
      branch_taken  = 1'b1;
      branch_target = 32'hFFFF_FFFF;
      tick();
      branch_taken = 1'b0;
      check("wrap_top", imem_addr, 32'hFFFF_FFFC);
      tick();
      check("wrap_addr",  imem_addr, 32'h0);
      check("wrap_pc",    if_id_pc,  32'hFFFF_FFFC);
      check("wrap_instr", if_id_instr, mem_word(32'hFFFF_FFFC));

      // Asynchronous reset in the middle of a stall with nonzero counters.
      stall = 1'b1;
      tick(2);
      check("pre_rst_scnt", 32'(stall_cnt), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state("async");

      // Continuous stall after release: counter saturates at all-ones.
      tick();
      rst_n = 1'b1;
      tick(20);
      check("sat_scnt", 32'(stall_cnt), 32'hF);
      check("sat_addr", imem_addr, 32'h0);
      check("sat_valid", 32'(if_id_valid), 32'h0);
      stall = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
